// File: rtl/ifetch_if.sv
// Memory read port between the fetch unit (master) and instruction memory (slave).
// Handshake: the master holds mem_req_o and mem_addr_o steady until a cycle in which
// mem_gnt_i is high; that cycle transfers the request. Exactly one response follows,
// signalled by mem_rvalid_i, with mem_rdata_i and mem_err_i qualified by it. At most
// one request is outstanding at any time.
interface ifetch_if #(
  parameter int ADDR_LEN = 32
) ();
  logic                mem_req_o;
  logic [ADDR_LEN-1:0] mem_addr_o;
  logic                mem_gnt_i;
  logic                mem_rvalid_i;
  logic [31:0]         mem_rdata_i;
  logic                mem_err_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_gnt_i,
    input  mem_rvalid_i,
    input  mem_rdata_i,
    input  mem_err_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_gnt_i,
    output mem_rvalid_i,
    output mem_rdata_i,
    output mem_err_i
  );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch unit. Follows the PC published by the control unit, reads the
// word at that PC over the memory port and presents it until the PC moves again.
// Any PC movement (normal advance or redirect) discards the current word and refetches.
// All outputs are registered, so a PC change seen at edge N shows up as a request
// after edge N+1, and with a same-cycle grant and next-cycle response the word is
// valid after edge N+3.
module ifetch #(
  parameter int ADDR_LEN    = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [ADDR_LEN-1:0] pc_i,
  output logic                inst_valid_o,
  output logic [31:0]         inst_o,
  output logic                fault_o,
  output logic [1:0]          dbg_state_o,
  ifetch_if.master            mem
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  // Value of the wait counter during the last cycle a response is still accepted.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t              r_state,   w_state_next;
  logic [ADDR_LEN-1:0] r_held_pc, w_held_next;
  logic                r_req,     w_req_next;
  logic [ADDR_LEN-1:0] r_addr,    w_addr_next;
  logic                r_stale,   w_stale_next;
  logic [CNT_W-1:0]    r_cnt,     w_cnt_next;
  logic                r_valid,   w_valid_next;
  logic [31:0]         r_inst,    w_inst_next;
  logic                r_fault,   w_fault_next;

  logic w_pc_moved;
  logic w_stale_now;

  assign w_pc_moved  = (pc_i != r_held_pc);
  // A response racing a PC change in the same cycle belongs to the old PC.
  assign w_stale_now = r_stale | w_pc_moved;

  assign inst_valid_o   = r_valid;
  assign inst_o         = r_inst;
  assign fault_o        = r_fault;
  assign dbg_state_o    = r_state;
  assign mem.mem_req_o  = r_req;
  assign mem.mem_addr_o = r_addr;

  // State and output registers; reset returns to REQ with everything cleared.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= S_REQ;
      r_held_pc <= '0;
      r_req     <= 1'b0;
      r_addr    <= '0;
      r_stale   <= 1'b0;
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_inst    <= '0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_held_pc <= w_held_next;
      r_req     <= w_req_next;
      r_addr    <= w_addr_next;
      r_stale   <= w_stale_next;
      r_cnt     <= w_cnt_next;
      r_valid   <= w_valid_next;
      r_inst    <= w_inst_next;
      r_fault   <= w_fault_next;
    end
  end

  // Next-state and next-output decode for the fetch FSM.
  always_comb begin
    w_state_next = r_state;
    w_held_next  = r_held_pc;
    w_req_next   = 1'b0;
    w_addr_next  = r_addr;
    w_stale_next = r_stale;
    w_cnt_next   = r_cnt;
    w_valid_next = r_valid;
    w_inst_next  = r_inst;
    w_fault_next = r_fault;

    case (r_state)
      S_REQ: begin
        if (w_pc_moved) begin
          // Withdraw the request for the old address and re-present next cycle.
          w_held_next = pc_i;
        end else if (r_held_pc[1:0] != 2'b00) begin
          w_state_next = S_FAULT;
          w_fault_next = 1'b1;
        end else if (r_req && mem.mem_gnt_i) begin
          w_state_next = S_WAIT;
          w_cnt_next   = '0;
          w_stale_next = 1'b0;
        end else begin
          w_req_next  = 1'b1;
          w_addr_next = r_held_pc;
        end
      end

      S_WAIT: begin
        w_cnt_next = r_cnt + CNT_W'(1);
        if (w_pc_moved) begin
          w_held_next = pc_i;
        end
        if (mem.mem_rvalid_i) begin
          if (w_stale_now) begin
            w_stale_next = 1'b0;
            w_state_next = S_REQ;
          end else if (mem.mem_err_i) begin
            w_state_next = S_FAULT;
            w_fault_next = 1'b1;
          end else begin
            w_inst_next  = mem.mem_rdata_i;
            w_valid_next = 1'b1;
            w_state_next = S_HOLD;
          end
        end else if (r_cnt == TO_LAST) begin
          // Timeout on a stale fetch just refetches; a late response lands in REQ and is ignored.
          w_stale_next = 1'b0;
          if (w_stale_now) begin
            w_state_next = S_REQ;
          end else begin
            w_state_next = S_FAULT;
            w_fault_next = 1'b1;
          end
        end else if (w_pc_moved) begin
          w_stale_next = 1'b1;
        end
      end

      S_HOLD: begin
        if (w_pc_moved) begin
          w_valid_next = 1'b0;
          w_held_next  = pc_i;
          w_state_next = S_REQ;
        end
      end

      S_FAULT: begin
        w_valid_next = 1'b0;
        if (w_pc_moved) begin
          w_fault_next = 1'b0;
          w_held_next  = pc_i;
          w_state_next = S_REQ;
        end
      end

      default: begin
        w_state_next = S_REQ;
      end
    endcase
  end

endmodule
